// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory port between instruction fetch (IF) and
//   data memory (DM). Each access runs IDLE -> ACCESS -> RESP -> IDLE and
//   takes MEM_LAT+3 cycles: the grant is registered in IDLE, Mem_En pulses
//   for the first ACCESS cycle, read data is captured MEM_LAT cycles later,
//   and the granted requester's Ack pulses in RESP.
//   DM has fixed priority over IF.
//   Optional macro MEM_ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive DM
//   grants made while IF was waiting, the next arbitration with IF_Req set
//   goes to IF.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic        DM_Req,
  input  logic        DM_We,
  input  logic [31:0] Mem_Rdata,
  output logic        Mux_Sel,
  output logic        Mem_En,
  output logic        Mem_We,
  output logic [31:0] IF_Rdata,
  output logic [31:0] DM_Rdata,
  output logic        IF_Ack,
  output logic        DM_Ack,
  output logic        IF_Stall,
  output logic        DM_Stall
);

  // Reject out-of-range configurations at elaboration time.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  logic [1:0] state;
  logic [3:0] lat_cnt;
  logic       dm_store;   // current access is a DM store: nothing to capture
  logic       any_req;
  logic       pick_dm;    // arbitration result, meaningful only in IDLE

  assign any_req = IF_Req | DM_Req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       starve_hit;

  assign starve_hit = (starve_cnt == STARVE_LIMIT);

  // DM priority, overridden in favour of a waiting IF once the limit is reached.
  always_comb begin
    pick_dm = DM_Req & ~(IF_Req & starve_hit);
  end

  // Count DM grants that bypass a waiting IF; any IF grant or idle IF clears it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (IF_Req && pick_dm) begin
        starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  // Strict fixed DM priority.
  always_comb begin
    pick_dm = DM_Req;
  end
`endif

  // Access sequencer: grant, strobe, latency wait, capture and acknowledge.
  // Mux_Sel doubles as the registered grant since it is held from the
  // IDLE->ACCESS edge until the RESP->IDLE edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      dm_store <= 1'b0;
      Mux_Sel  <= 1'b0;
      Mem_En   <= 1'b0;
      Mem_We   <= 1'b0;
      IF_Ack   <= 1'b0;
      DM_Ack   <= 1'b0;
      IF_Rdata <= '0;
      DM_Rdata <= '0;
    end else begin
      Mem_En <= 1'b0;
      Mem_We <= 1'b0;
      IF_Ack <= 1'b0;
      DM_Ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          Mux_Sel <= 1'b0;
          if (any_req) begin
            Mux_Sel  <= pick_dm;
            dm_store <= pick_dm & DM_We;
            Mem_En   <= 1'b1;
            Mem_We   <= pick_dm & DM_We;
            lat_cnt  <= LAT_LOAD;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // lat_cnt reaches 0 exactly in the cycle Mem_Rdata becomes valid.
          if (lat_cnt == 4'd0) begin
            if (Mux_Sel) begin
              if (!dm_store) begin
                DM_Rdata <= Mem_Rdata;
              end
              DM_Ack <= 1'b1;
            end else begin
              IF_Rdata <= Mem_Rdata;
              IF_Ack   <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          Mux_Sel <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          Mux_Sel <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Pipeline stalls: requester waits until its Ack cycle.
  always_comb begin
    IF_Stall = IF_Req & ~IF_Ack;
    DM_Stall = DM_Req & ~DM_Ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed-vector bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=2.
//   Cycle c of a scenario is the clock period in which stimulus is applied;
//   outputs are sampled 2 time units after the rising edge that starts it.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IF_Req;
  logic        DM_Req;
  logic        DM_We;
  logic [31:0] Mem_Rdata;
  logic        Mux_Sel;
  logic        Mem_En;
  logic        Mem_We;
  logic [31:0] IF_Rdata;
  logic [31:0] DM_Rdata;
  logic        IF_Ack;
  logic        DM_Ack;
  logic        IF_Stall;
  logic        DM_Stall;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  mem_port_arbiter #(
    .MEM_LAT   (2),
    .STARVE_MAX(2)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .IF_Req   (IF_Req),
    .DM_Req   (DM_Req),
    .DM_We    (DM_We),
    .Mem_Rdata(Mem_Rdata),
    .Mux_Sel  (Mux_Sel),
    .Mem_En   (Mem_En),
    .Mem_We   (Mem_We),
    .IF_Rdata (IF_Rdata),
    .DM_Rdata (DM_Rdata),
    .IF_Ack   (IF_Ack),
    .DM_Ack   (DM_Ack),
    .IF_Stall (IF_Stall),
    .DM_Stall (DM_Stall)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset     = 1'b1;
    IF_Req    = 1'b0;
    DM_Req    = 1'b0;
    DM_We     = 1'b0;
    Mem_Rdata = JUNK;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++; if (Mux_Sel !== 1'b0) begin n_err++; $display("FAIL reset Mux_Sel got %b exp 0", Mux_Sel); end
    n_vec++; if (Mem_En !== 1'b0) begin n_err++; $display("FAIL reset Mem_En got %b exp 0", Mem_En); end
    n_vec++; if (Mem_We !== 1'b0) begin n_err++; $display("FAIL reset Mem_We got %b exp 0", Mem_We); end
    n_vec++; if (IF_Ack !== 1'b0 || DM_Ack !== 1'b0) begin n_err++; $display("FAIL reset acks got %b%b exp 00", IF_Ack, DM_Ack); end
    n_vec++; if (IF_Rdata !== 32'h0) begin n_err++; $display("FAIL reset IF_Rdata got %h exp 0", IF_Rdata); end
    n_vec++; if (DM_Rdata !== 32'h0) begin n_err++; $display("FAIL reset DM_Rdata got %h exp 0", DM_Rdata); end
    n_vec++; if (IF_Stall !== 1'b0 || DM_Stall !== 1'b0) begin n_err++; $display("FAIL reset stalls got %b%b exp 00", IF_Stall, DM_Stall); end
    next_cycle();
  endtask

  task automatic test_fetch();
    logic [31:0] e_ifd;
    apply_reset();
    for (int c = 0; c <= 6; c++) begin
      IF_Req    = (c <= 4);
      Mem_Rdata = (c == 3) ? 32'h8C0A_0004 : JUNK;
      e_ifd     = (c >= 4) ? 32'h8C0A_0004 : 32'h0;
      #1;
      n_vec++; if (Mux_Sel !== 1'b0) begin n_err++; $display("FAIL fetch Mux_Sel c=%0d got %b exp 0", c, Mux_Sel); end
      n_vec++; if (Mem_En !== (c == 1)) begin n_err++; $display("FAIL fetch Mem_En c=%0d got %b exp %b", c, Mem_En, (c == 1)); end
      n_vec++; if (Mem_We !== 1'b0) begin n_err++; $display("FAIL fetch Mem_We c=%0d got %b exp 0", c, Mem_We); end
      n_vec++; if (IF_Ack !== (c == 4)) begin n_err++; $display("FAIL fetch IF_Ack c=%0d got %b exp %b", c, IF_Ack, (c == 4)); end
      n_vec++; if (IF_Stall !== (c <= 3)) begin n_err++; $display("FAIL fetch IF_Stall c=%0d got %b exp %b", c, IF_Stall, (c <= 3)); end
      n_vec++; if (IF_Rdata !== e_ifd) begin n_err++; $display("FAIL fetch IF_Rdata c=%0d got %h exp %h", c, IF_Rdata, e_ifd); end
      n_vec++; if (DM_Ack !== 1'b0) begin n_err++; $display("FAIL fetch DM_Ack c=%0d got %b exp 0", c, DM_Ack); end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    logic [31:0] e_dmd;
    logic [31:0] e_ifd;
    apply_reset();
    for (int c = 0; c <= 11; c++) begin
      DM_Req    = (c <= 4);
      IF_Req    = (c <= 9);
      DM_We     = 1'b0;
      Mem_Rdata = (c == 3) ? 32'h1111_2222 : (c == 8) ? 32'h3333_4444 : JUNK;
      e_dmd     = (c >= 4) ? 32'h1111_2222 : 32'h0;
      e_ifd     = (c >= 9) ? 32'h3333_4444 : 32'h0;
      #1;
      n_vec++; if (Mux_Sel !== (c >= 1 && c <= 4)) begin n_err++; $display("FAIL contention Mux_Sel c=%0d got %b exp %b", c, Mux_Sel, (c >= 1 && c <= 4)); end
      n_vec++; if (Mem_En !== (c == 1 || c == 6)) begin n_err++; $display("FAIL contention Mem_En c=%0d got %b exp %b", c, Mem_En, (c == 1 || c == 6)); end
      n_vec++; if (DM_Ack !== (c == 4)) begin n_err++; $display("FAIL contention DM_Ack c=%0d got %b exp %b", c, DM_Ack, (c == 4)); end
      n_vec++; if (IF_Ack !== (c == 9)) begin n_err++; $display("FAIL contention IF_Ack c=%0d got %b exp %b", c, IF_Ack, (c == 9)); end
      n_vec++; if (DM_Rdata !== e_dmd) begin n_err++; $display("FAIL contention DM_Rdata c=%0d got %h exp %h", c, DM_Rdata, e_dmd); end
      n_vec++; if (IF_Rdata !== e_ifd) begin n_err++; $display("FAIL contention IF_Rdata c=%0d got %h exp %h", c, IF_Rdata, e_ifd); end
      n_vec++; if (IF_Stall !== (c <= 8)) begin n_err++; $display("FAIL contention IF_Stall c=%0d got %b exp %b", c, IF_Stall, (c <= 8)); end
      next_cycle();
    end
  endtask

  task automatic test_store();
    apply_reset();
    // Preload DM_Rdata with a load returning 0x00000011.
    for (int c = 0; c <= 5; c++) begin
      DM_Req    = (c <= 4);
      DM_We     = 1'b0;
      Mem_Rdata = (c == 3) ? 32'h0000_0011 : JUNK;
      next_cycle();
    end
    for (int s = 0; s <= 6; s++) begin
      DM_Req    = (s <= 4);
      DM_We     = (s <= 4);
      Mem_Rdata = 32'hFFFF_FFFF;
      #1;
      n_vec++; if (Mem_En !== (s == 1)) begin n_err++; $display("FAIL store Mem_En s=%0d got %b exp %b", s, Mem_En, (s == 1)); end
      n_vec++; if (Mem_We !== (s == 1)) begin n_err++; $display("FAIL store Mem_We s=%0d got %b exp %b", s, Mem_We, (s == 1)); end
      n_vec++; if (Mux_Sel !== (s >= 1 && s <= 4)) begin n_err++; $display("FAIL store Mux_Sel s=%0d got %b exp %b", s, Mux_Sel, (s >= 1 && s <= 4)); end
      n_vec++; if (DM_Ack !== (s == 4)) begin n_err++; $display("FAIL store DM_Ack s=%0d got %b exp %b", s, DM_Ack, (s == 4)); end
      n_vec++; if (DM_Rdata !== 32'h0000_0011) begin n_err++; $display("FAIL store DM_Rdata s=%0d got %h exp 00000011", s, DM_Rdata); end
      n_vec++; if (DM_Stall !== (s <= 3)) begin n_err++; $display("FAIL store DM_Stall s=%0d got %b exp %b", s, DM_Stall, (s <= 3)); end
      next_cycle();
    end
    DM_We = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      IF_Req    = (c < 2);
      Reset     = (c == 2);
      Mem_Rdata = (c == 3) ? 32'hCAFE_0001 : JUNK;
      #1;
      n_vec++; if (Mem_En !== (c == 1)) begin n_err++; $display("FAIL rstmid Mem_En c=%0d got %b exp %b", c, Mem_En, (c == 1)); end
      n_vec++; if (Mux_Sel !== 1'b0) begin n_err++; $display("FAIL rstmid Mux_Sel c=%0d got %b exp 0", c, Mux_Sel); end
      n_vec++; if (IF_Ack !== 1'b0) begin n_err++; $display("FAIL rstmid IF_Ack c=%0d got %b exp 0", c, IF_Ack); end
      n_vec++; if (IF_Rdata !== 32'h0) begin n_err++; $display("FAIL rstmid IF_Rdata c=%0d got %h exp 0", c, IF_Rdata); end
      next_cycle();
    end
    Reset = 1'b0;
  endtask

  task automatic test_dropped_request();
    logic [31:0] e_dmd;
    apply_reset();
    for (int c = 0; c <= 7; c++) begin
      DM_Req    = (c == 0);
      DM_We     = 1'b0;
      Mem_Rdata = (c == 3) ? 32'hDEAD_BEEF : JUNK;
      e_dmd     = (c >= 4) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      n_vec++; if (Mem_En !== (c == 1)) begin n_err++; $display("FAIL dropped Mem_En c=%0d got %b exp %b", c, Mem_En, (c == 1)); end
      n_vec++; if (Mux_Sel !== (c >= 1 && c <= 4)) begin n_err++; $display("FAIL dropped Mux_Sel c=%0d got %b exp %b", c, Mux_Sel, (c >= 1 && c <= 4)); end
      n_vec++; if (DM_Ack !== (c == 4)) begin n_err++; $display("FAIL dropped DM_Ack c=%0d got %b exp %b", c, DM_Ack, (c == 4)); end
      n_vec++; if (DM_Rdata !== e_dmd) begin n_err++; $display("FAIL dropped DM_Rdata c=%0d got %h exp %h", c, DM_Rdata, e_dmd); end
      n_vec++; if (DM_Stall !== (c == 0)) begin n_err++; $display("FAIL dropped DM_Stall c=%0d got %b exp %b", c, DM_Stall, (c == 0)); end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic [5:0] exp_dm;
    logic       g;
    int         k;
    int         ph;
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_dm = 6'b011011;   // bit k = grant k: DM, DM, IF, DM, DM, IF
`else
    exp_dm = 6'b111111;
`endif
    apply_reset();
    for (int c = 0; c <= 29; c++) begin
      IF_Req    = 1'b1;
      DM_Req    = 1'b1;
      DM_We     = 1'b0;
      Mem_Rdata = JUNK;
      k  = c / 5;
      ph = c % 5;
      g  = exp_dm[k];
      #1;
      n_vec++; if (Mem_En !== (ph == 1)) begin n_err++; $display("FAIL starve Mem_En c=%0d got %b exp %b", c, Mem_En, (ph == 1)); end
      if (ph >= 1) begin
        n_vec++; if (Mux_Sel !== g) begin n_err++; $display("FAIL starve Mux_Sel c=%0d got %b exp %b", c, Mux_Sel, g); end
      end
      n_vec++; if (DM_Ack !== (ph == 4 && g)) begin n_err++; $display("FAIL starve DM_Ack c=%0d got %b exp %b", c, DM_Ack, (ph == 4 && g)); end
      n_vec++; if (IF_Ack !== (ph == 4 && !g)) begin n_err++; $display("FAIL starve IF_Ack c=%0d got %b exp %b", c, IF_Ack, (ph == 4 && !g)); end
      next_cycle();
    end
  endtask

  initial begin
    Reset     = 1'b1;
    IF_Req    = 1'b0;
    DM_Req    = 1'b0;
    DM_We     = 1'b0;
    Mem_Rdata = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_reset_mid_access();
    test_dropped_request();
    test_starvation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and data memory access (DM) in the MIPS datapath.
- Drives the Sel input of the 32-bit 2:1 address mux: In0 = IF address, In1 = DM address.
- Sequences each access: issue, fixed-latency wait, read-data capture, acknowledge.
- Generates per-requester stall signals for the pipeline.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the Mem_En cycle to valid Mem_Rdata (legal 1..15).
- STARVE_MAX, 4, consecutive DM grants tolerated while IF waits (used only with the optional feature; legal 1..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IF_Req  in  1  fetch request; held with its address until IF_Ack.
- DM_Req  in  1  data request; held with address/data/DM_We until DM_Ack.
- DM_We  in  1  1 = store, 0 = load.
- Mem_Rdata  in  32  memory read data.
- Mux_Sel  out  1  address mux select: 0 = IF, 1 = DM.
- Mem_En  out  1  memory access strobe, one cycle per access.
- Mem_We  out  1  memory write strobe.
- IF_Rdata  out  32  captured instruction word.
- DM_Rdata  out  32  captured load data.
- IF_Ack  out  1  one-cycle IF completion pulse.
- DM_Ack  out  1  one-cycle DM completion pulse.
- IF_Stall  out  1  IF_Req & ~IF_Ack (combinational).
- DM_Stall  out  1  DM_Req & ~DM_Ack (combinational).

Behaviour:
- Single clock Clk; reset is synchronous and active-high on Reset.
- Reset values:
  - FSM is in IDLE.
  - Mux_Sel, Mem_En, Mem_We, IF_Ack and DM_Ack are 0.
  - IF_Rdata and DM_Rdata are 0.
  - Latency counter and starvation counter are 0.
- FSM states and transitions:
  - IDLE -> ACCESS -> RESP -> IDLE.
  - Requests are sampled only in IDLE. A request present during RESP is ignored until the next IDLE cycle.
- IDLE, cycle T with at least one request:
  - Arbitration: DM_Req wins over IF_Req (fixed priority).
  - Registered grant and select: Mux_Sel = 1 for a DM grant, 0 for an IF grant.
  - Latency counter loaded with MEM_LAT.
  - Next state is ACCESS.
- ACCESS:
  - First cycle (T+1):
    - Mem_En = 1.
    - Mem_We = DM_We for a DM grant, else 0.
  - Remaining cycles:
    - Mem_En = 0 and Mem_We = 0.
    - Counter decrements each cycle.
  - Mem_Rdata is valid in cycle T+1+MEM_LAT.
  - For a load or fetch, Mem_Rdata is captured at the end of that cycle into the granted requester's Rdata register.
  - Stores capture nothing; DM_Rdata holds its value.
  - The state goes to RESP after that cycle.
- RESP, cycle T+MEM_LAT+2:
  - Ack pulses for the granted requester only.
  - Rdata is already valid.
  - Next state is IDLE, giving a one-cycle bubble.
- Mux_Sel is held stable through ACCESS and RESP. It returns to 0 in IDLE.
- Total access time is MEM_LAT+3 cycles per access. Back-to-back accesses issue Mem_En every MEM_LAT+3 cycles.
- Requester drops Req mid-access: the access still completes, the Ack still pulses, and the data is still captured.
- Req held high through its Ack: treated as a new request in the following IDLE cycle.
- Reset mid-access:
  - Access is aborted; no Ack is produced.
  - All outputs take reset values in the cycle after the Reset edge.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments on each DM grant made while IF_Req = 1.
  - When the counter equals STARVE_MAX, the next IDLE arbitration with IF_Req = 1 grants IF even if DM_Req = 1.
  - The counter clears on any IF grant, and in any IDLE arbitration where IF_Req = 0.
- Undefined: strict DM priority; no counter logic is present.

Test Plan:
- Fetch read: MEM_LAT=2, IF_Req=1 from cycle 0, Mem_Rdata=0x8C0A0004 in cycle 3 -> Mux_Sel=0, Mem_En=1 only in cycle 1, IF_Ack=1 only in cycle 4, IF_Rdata=0x8C0A0004, IF_Stall=1 in cycles 0-3 and 0 in cycle 4.
- Contention: IF_Req=DM_Req=1 from cycle 0, DM_We=0 -> DM access: Mux_Sel=1 in cycles 1-4, DM_Ack=1 in cycle 4. IF access: Mem_En=1 in cycle 6, IF_Ack=1 in cycle 9.
- Store: DM_Req=1, DM_We=1 at cycle 0, DM_Rdata preloaded 0x00000011 -> Mem_En=Mem_We=1 in cycle 1 only, DM_Ack=1 in cycle 4, DM_Rdata stays 0x00000011.
- Reset mid-access: IF_Req at cycle 0, Reset=1 in cycle 2 -> Mem_En, Mux_Sel and IF_Ack are 0 from cycle 3 on; no IF_Ack ever appears for that access.
- Starvation guard (macro defined, STARVE_MAX=2): IF_Req=DM_Req=1 held continuously -> grant sequence DM, DM, IF, DM, DM, IF. With the macro undefined -> DM on every grant and no IF_Ack.
- Dropped request: DM_Req=1 in cycle 0 only, Mem_Rdata=0xDEADBEEF in cycle 3 -> DM_Ack=1 in cycle 4, DM_Rdata=0xDEADBEEF, FSM in IDLE in cycle 5 with no new access.
